// File: rtl/ps16_bus_arbiter.sv
// ps16_bus_arbiter: sequences the 68000 nBR / nBG / nBGACK handshake so the
// Pi-side access FSM only runs bus cycles while PiStorm16 owns the Amiga bus.
// Optional idle auto-release of the bus is compiled in with the macro
// PS16_ARB_AUTO_RELEASE_EN; without it, ownership ends only on acq_req=0 or
// Amiga reset.
module ps16_bus_arbiter #(
  parameter int unsigned GRANT_TIMEOUT = 255,
  parameter int unsigned IDLE_HOLD     = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       sys_clk,
  input  logic       nSYS_RESET,
  input  logic       mc_clk_falling,
  input  logic       acq_req,
  input  logic       access_busy,
  input  logic       bg_n_sync,
  input  logic       as_n_sync,
  input  logic       bgack_n_sync,
  input  logic       reset_n_sync,
  output logic       br_drive,
  output logic       bgack_drive,
  output logic       bus_owned,
  output logic       grant_timeout,
  output logic [2:0] arb_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_FREE = 3'd2,
    ST_OWN       = 3'd3,
    ST_RELEASE   = 3'd4
  } arb_state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(GRANT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

`ifdef PS16_ARB_AUTO_RELEASE_EN
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(IDLE_HOLD);
`else
  // Hold limit has no function without auto-release; kept referenced only.
  logic [CNT_W-1:0] w_unused_hold;
  assign w_unused_hold = CNT_W'(IDLE_HOLD);
`endif

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_br, w_br_nxt;
  logic             r_bgack, w_bgack_nxt;
  logic             r_owned, w_owned_nxt;
  logic             r_timeout, w_timeout_nxt;

  // Saturating strobe counter increment; never wraps past all-ones.
  always_comb begin
    w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  end

  // Next-state and next-output decode for the arbitration handshake.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_br_nxt      = r_br;
    w_bgack_nxt   = r_bgack;
    w_owned_nxt   = r_owned;
    w_timeout_nxt = r_timeout;

    if ((r_state != ST_IDLE) && !reset_n_sync) begin
      // Amiga reset drops every drive; the timeout flag is left alone.
      w_state_nxt = ST_IDLE;
      w_br_nxt    = 1'b0;
      w_bgack_nxt = 1'b0;
      w_owned_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!acq_req) begin
            w_timeout_nxt = 1'b0;
          end else if (!r_timeout) begin
            w_state_nxt = ST_REQ;
            w_br_nxt    = 1'b1;
            w_cnt_nxt   = '0;
          end
        end

        ST_REQ: begin
          if (!acq_req) begin
            // Abort beats a coincident strobe, so no timeout is flagged.
            w_state_nxt = ST_IDLE;
            w_br_nxt    = 1'b0;
          end else if (mc_clk_falling) begin
            if (!bg_n_sync) begin
              w_state_nxt = ST_WAIT_FREE;
            end else begin
              w_cnt_nxt = w_cnt_inc;
              if (w_cnt_inc >= TIMEOUT_LIM) begin
                w_state_nxt   = ST_IDLE;
                w_br_nxt      = 1'b0;
                w_timeout_nxt = 1'b1;
              end
            end
          end
        end

        ST_WAIT_FREE: begin
          if (!acq_req) begin
            w_state_nxt = ST_IDLE;
            w_br_nxt    = 1'b0;
          end else if (mc_clk_falling && as_n_sync && bgack_n_sync) begin
            // nBGACK asserts on the same edge nBR releases.
            w_state_nxt = ST_OWN;
            w_bgack_nxt = 1'b1;
            w_br_nxt    = 1'b0;
            w_owned_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end
        end

        ST_OWN: begin
          if (!acq_req && !access_busy) begin
            w_state_nxt = ST_RELEASE;
            w_owned_nxt = 1'b0;
          end
`ifdef PS16_ARB_AUTO_RELEASE_EN
          else if (access_busy) begin
            w_cnt_nxt = '0;
          end else if (mc_clk_falling) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= HOLD_LIM) begin
              w_state_nxt = ST_RELEASE;
              w_owned_nxt = 1'b0;
            end
          end
`endif
        end

        ST_RELEASE: begin
          // nBGACK lets go a strobe after bus_owned has already fallen.
          if (mc_clk_falling) begin
            w_state_nxt = ST_IDLE;
            w_bgack_nxt = 1'b0;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_br_nxt    = 1'b0;
          w_bgack_nxt = 1'b0;
          w_owned_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!nSYS_RESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_br      <= 1'b0;
      r_bgack   <= 1'b0;
      r_owned   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_br      <= w_br_nxt;
      r_bgack   <= w_bgack_nxt;
      r_owned   <= w_owned_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign br_drive      = r_br;
  assign bgack_drive   = r_bgack;
  assign bus_owned     = r_owned;
  assign grant_timeout = r_timeout;
  assign arb_state     = r_state;

endmodule

// File: tb/tb_ps16_bus_arbiter.sv
// Bench for ps16_bus_arbiter: directed vectors, a phase-level reference model
// compared every cycle, and hand-computed expectations at key points.
module tb_ps16_bus_arbiter;

  localparam int unsigned GT = 4;
  localparam int unsigned IH = 2;

  logic       sys_clk = 1'b0;
  logic       nSYS_RESET;
  logic       mc_clk_falling;
  logic       acq_req;
  logic       access_busy;
  logic       bg_n_sync;
  logic       as_n_sync;
  logic       bgack_n_sync;
  logic       reset_n_sync;
  logic       br_drive;
  logic       bgack_drive;
  logic       bus_owned;
  logic       grant_timeout;
  logic [2:0] arb_state;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model: bus phase 0..4, grant-wait strobes, timeout flag.
  int m_phase = 0;
  int m_waits = 0;
  bit m_to    = 1'b0;
`ifdef PS16_ARB_AUTO_RELEASE_EN
  int m_idle  = 0;
`endif

  ps16_bus_arbiter #(
    .GRANT_TIMEOUT(GT),
    .IDLE_HOLD    (IH),
    .CNT_W        (8)
  ) dut (
    .sys_clk       (sys_clk),
    .nSYS_RESET    (nSYS_RESET),
    .mc_clk_falling(mc_clk_falling),
    .acq_req       (acq_req),
    .access_busy   (access_busy),
    .bg_n_sync     (bg_n_sync),
    .as_n_sync     (as_n_sync),
    .bgack_n_sync  (bgack_n_sync),
    .reset_n_sync  (reset_n_sync),
    .br_drive      (br_drive),
    .bgack_drive   (bgack_drive),
    .bus_owned     (bus_owned),
    .grant_timeout (grant_timeout),
    .arb_state     (arb_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: advance the bus phase from the sampled inputs.
  always @(posedge sys_clk) begin : model
    int ph;
    int w;
    bit to;
`ifdef PS16_ARB_AUTO_RELEASE_EN
    int idl;
    idl = m_idle;
`endif
    ph = m_phase;
    w  = m_waits;
    to = m_to;
    if (!nSYS_RESET) begin
      ph = 0; w = 0; to = 1'b0;
`ifdef PS16_ARB_AUTO_RELEASE_EN
      idl = 0;
`endif
    end else if (ph != 0 && !reset_n_sync) begin
      ph = 0;
    end else begin
      case (ph)
        0: if (!acq_req) to = 1'b0;
           else if (!to) begin ph = 1; w = 0; end
        1: if (!acq_req) ph = 0;
           else if (mc_clk_falling) begin
             if (!bg_n_sync) ph = 2;
             else begin
               w = w + 1;
               if (w >= int'(GT)) begin ph = 0; to = 1'b1; end
             end
           end
        2: if (!acq_req) ph = 0;
           else if (mc_clk_falling && as_n_sync && bgack_n_sync) begin
             ph = 3;
`ifdef PS16_ARB_AUTO_RELEASE_EN
             idl = 0;
`endif
           end
        3: begin
             if (!acq_req && !access_busy) ph = 4;
`ifdef PS16_ARB_AUTO_RELEASE_EN
             else if (access_busy) idl = 0;
             else if (mc_clk_falling) begin
               idl = idl + 1;
               if (idl >= int'(IH)) ph = 4;
             end
`endif
           end
        4: if (mc_clk_falling) ph = 0;
        default: ph = 0;
      endcase
    end
    m_phase <= ph;
    m_waits <= w;
    m_to    <= to;
`ifdef PS16_ARB_AUTO_RELEASE_EN
    m_idle  <= idl;
`endif
  end

  // Every-cycle comparison: drives follow directly from the bus phase.
  always @(negedge sys_clk) begin
    if (cmp_en) begin
      check("model br_drive",      32'(br_drive),      32'(m_phase == 1 || m_phase == 2));
      check("model bgack_drive",   32'(bgack_drive),   32'(m_phase == 3 || m_phase == 4));
      check("model bus_owned",     32'(bus_owned),     32'(m_phase == 3));
      check("model grant_timeout", 32'(grant_timeout), 32'(m_to));
      check("model arb_state",     32'(arb_state),     32'(m_phase));
    end
  end

  task automatic step(input bit s);
    mc_clk_falling = s;
    @(negedge sys_clk);
  endtask

  task automatic expect_out(input string name, input int st, input bit br,
                            input bit bgk, input bit own, input bit to);
    check({name, ".arb_state"},     32'(arb_state),     32'(st));
    check({name, ".br_drive"},      32'(br_drive),      32'(br));
    check({name, ".bgack_drive"},   32'(bgack_drive),   32'(bgk));
    check({name, ".bus_owned"},     32'(bus_owned),     32'(own));
    check({name, ".grant_timeout"}, 32'(grant_timeout), 32'(to));
  endtask

  initial begin
    nSYS_RESET = 1'b0; mc_clk_falling = 1'b0; acq_req = 1'b0; access_busy = 1'b0;
    bg_n_sync = 1'b1; as_n_sync = 1'b1; bgack_n_sync = 1'b1; reset_n_sync = 1'b1;
    step(0);
    cmp_en = 1'b1;
    step(0);
    expect_out("reset", 0, 0, 0, 0, 0);
    nSYS_RESET = 1'b1;

    // Normal acquire: nBG low on the third strobe.
    acq_req = 1'b1;
    step(0);        expect_out("acq_req_rise", 1, 1, 0, 0, 0);
    step(1); step(1);
    bg_n_sync = 1'b0;
    step(1);        expect_out("grant_seen", 2, 1, 0, 0, 0);
    step(1);        expect_out("own_entry", 3, 0, 1, 1, 0);
    acq_req = 1'b0;
    step(0);        expect_out("release_entry", 4, 0, 1, 0, 0);
    step(0);        expect_out("release_hold", 4, 0, 1, 0, 0);
    step(1);        expect_out("release_done", 0, 0, 0, 0, 0);
    bg_n_sync = 1'b1;

    // Grant timeout after GT strobes, then sticky until acq_req drops.
    acq_req = 1'b1;
    step(0);
    step(1); step(1); step(1);
    expect_out("timeout_pre", 1, 1, 0, 0, 0);
    step(1);        expect_out("timeout_hit", 0, 0, 0, 0, 1);
    step(1); step(0);
    expect_out("timeout_sticky", 0, 0, 0, 0, 1);
    acq_req = 1'b0;
    step(0);        expect_out("timeout_clear", 0, 0, 0, 0, 0);

    // Abort coinciding with the strobe that would have timed out.
    acq_req = 1'b1;
    step(0);
    step(1); step(1); step(1);
    acq_req = 1'b0;
    step(1);        expect_out("abort_wins", 0, 0, 0, 0, 0);

    // Wait for bus free, then busy-deferred release.
    acq_req = 1'b1;
    step(0);
    bg_n_sync = 1'b0; as_n_sync = 1'b0;
    step(1); step(1); step(1);
    expect_out("wait_as_busy", 2, 1, 0, 0, 0);
    as_n_sync = 1'b1; bgack_n_sync = 1'b0;
    step(1);        expect_out("wait_bgack_busy", 2, 1, 0, 0, 0);
    bgack_n_sync = 1'b1;
    step(0);        expect_out("wait_no_strobe", 2, 1, 0, 0, 0);
    step(1);        expect_out("free_own", 3, 0, 1, 1, 0);
    access_busy = 1'b1;
    step(0);
    acq_req = 1'b0;
    step(0); step(0);
    expect_out("busy_defers", 3, 0, 1, 1, 0);
    access_busy = 1'b0;
    step(0);        expect_out("busy_fell", 4, 0, 1, 0, 0);
    step(1);        expect_out("busy_rel_done", 0, 0, 0, 0, 0);

    // Abort while waiting for the bus to go free.
    acq_req = 1'b1;
    step(0);
    as_n_sync = 1'b0;
    step(1);
    acq_req = 1'b0;
    step(0);        expect_out("abort_wait_free", 0, 0, 0, 0, 0);
    as_n_sync = 1'b1;

    // Amiga reset in OWN, then system reset in REQ.
    acq_req = 1'b1;
    step(0); step(1); step(1);
    expect_out("own_again", 3, 0, 1, 1, 0);
    reset_n_sync = 1'b0;
    step(0);        expect_out("amiga_reset", 0, 0, 0, 0, 0);
    reset_n_sync = 1'b1;
    step(0);        expect_out("rearm_after_reset", 1, 1, 0, 0, 0);
    nSYS_RESET = 1'b0;
    step(0);        expect_out("sys_reset_req", 0, 0, 0, 0, 0);
    nSYS_RESET = 1'b1; acq_req = 1'b0;
    step(0);

    // Idle ownership: auto-release after IH strobes, else held.
    acq_req = 1'b1;
    step(0); step(1); step(1);
    step(1); step(1);
`ifdef PS16_ARB_AUTO_RELEASE_EN
    expect_out("auto_release", 4, 0, 1, 0, 0);
    step(1);        expect_out("auto_idle", 0, 0, 0, 0, 0);
    step(0);        expect_out("auto_rerequest", 1, 1, 0, 0, 0);
    acq_req = 1'b0;
    step(0);
`else
    expect_out("own_held_idle", 3, 0, 1, 1, 0);
    acq_req = 1'b0;
    step(0);
    step(1);        expect_out("own_drop_idle", 0, 0, 0, 0, 0);
`endif
    bg_n_sync = 1'b1;
    step(0); step(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
